layer_stack: RTL and testbench

//  Parametrised N-layer paint canvas: owns NUM_LAYERS pixel memories and one active-layer selector.

---
 rtl/layer_stack_pkg.sv | 22 ++
 rtl/layer_stack_if.sv | 33 +++
 rtl/layer_stack_ram.sv | 31 +++
 rtl/layer_stack.sv | 225 ++++++++++++++++++++++
 tb/tb_layer_stack.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/layer_stack_pkg.sv
// Shared types for the layered paint canvas: colour type, "no paint" code,
// clear-sweep FSM states and a small colour helper.
package layer_stack_pkg;

  localparam int COLOR_WIDTH = 4;

  typedef logic [COLOR_WIDTH-1:0] color_t;

  // Stored in a pixel that carries no paint; also the eraser colour.
  localparam color_t COLOR_NONE = 4'h0;

  typedef enum logic [0:0] {
    CS_IDLE  = 1'b0,
    CS_CLEAR = 1'b1
  } clear_state_e;

  // True when a stored colour is real paint rather than transparency.
  function automatic logic color_present(input color_t c);
    return (c != COLOR_NONE);
  endfunction

endpackage

// File: rtl/layer_stack_if.sv
// Tool write bus and VGA pixel request/response bundle for layer_stack.
// Coordinates carry one code beyond the last column/row so that an
// out-of-range position stays representable even when WIDTH/HEIGHT is a
// power of two (for 640x480 the widths are the same 10/9 bits).
interface layer_stack_if #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) ();
  import layer_stack_pkg::*;

  localparam int X_W = $clog2(WIDTH + 1);
  localparam int Y_W = $clog2(HEIGHT + 1);

  logic           tool_valid;
  logic [X_W-1:0] tool_x;
  logic [Y_W-1:0] tool_y;
  color_t         tool_color;
  logic [X_W-1:0] request_x;
  logic [Y_W-1:0] request_y;
  color_t         pixel_color;
  logic           pixel_hit;

  modport master (
    output tool_valid, tool_x, tool_y, tool_color, request_x, request_y,
    input  pixel_color, pixel_hit
  );

  modport slave (
    input  tool_valid, tool_x, tool_y, tool_color, request_x, request_y,
    output pixel_color, pixel_hit
  );

endinterface

// File: rtl/layer_stack_ram.sv
// layer_ram: one layer's pixel store. Simple dual-port synchronous RAM,
// one write port and one registered read port; a read of the address being
// written in the same cycle returns the old contents.
module layer_ram
  import layer_stack_pkg::*;
#(
  parameter int DEPTH = 640 * 480,
  parameter int AW    = $clog2(640 * 480)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  color_t        wdata,
  input  logic [AW-1:0] raddr,
  output color_t        rdata
);

  color_t mem_r [DEPTH];
  color_t rdata_r;

  // Read-first memory: the read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata_r <= mem_r[raddr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/layer_stack.sv
// layer_stack: NUM_LAYERS-deep paint canvas. Tool writes go to the active
// layer; VGA requests return the topmost visible painted pixel two cycles
// after the request is registered.
// Optional hardware clear of the active layer: define LAYER_STACK_CLEAR_EN.
module layer_stack
  import layer_stack_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int NUM_LAYERS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          layer_toggle,
  input  logic [NUM_LAYERS-1:0]         layer_visible,
  input  logic                          clear_req,
  output logic [$clog2(NUM_LAYERS)-1:0] active_layer,
  output logic                          clear_busy,
  layer_stack_if.slave                  bus
);

  localparam int X_W   = $clog2(WIDTH + 1);
  localparam int Y_W   = $clog2(HEIGHT + 1);
  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int A_W   = $clog2(DEPTH);
  localparam int L_W   = $clog2(NUM_LAYERS);

  localparam logic [L_W-1:0] LAST_LAYER = L_W'(NUM_LAYERS - 1);
  localparam logic [X_W-1:0] X_LIMIT    = X_W'(WIDTH);
  localparam logic [Y_W-1:0] Y_LIMIT    = Y_W'(HEIGHT);

  logic [L_W-1:0] active_layer_r;
  logic           toggle_d_r;
  logic           tool_we_s;
  logic [A_W-1:0] tool_addr_s;
  logic           req_ok_s;
  logic [A_W-1:0] req_addr_s;
  logic [A_W-1:0] req_addr_r;
  logic           req_ok_r;
  logic           rd_ok_r;
  color_t         mix_color_s;
  logic           mix_hit_s;
  color_t         pixel_color_r;
  logic           pixel_hit_r;
  logic           clr_we_s;
  logic [L_W-1:0] clr_target_s;
  logic [A_W-1:0] clr_waddr_s;
  logic           busy_s;
  logic [A_W-1:0] ram_waddr_s;
  color_t         ram_wdata_s;
  logic [NUM_LAYERS-1:0] ram_we_s;
  color_t         rd_data_s [NUM_LAYERS];

  // Active-layer selector: one step per rising edge of layer_toggle, wrapping at the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_d_r     <= 1'b0;
      active_layer_r <= {L_W{1'b0}};
    end else begin
      toggle_d_r <= layer_toggle;
      if (layer_toggle && !toggle_d_r) begin
        if (active_layer_r == LAST_LAYER) begin
          active_layer_r <= {L_W{1'b0}};
        end else begin
          active_layer_r <= active_layer_r + L_W'(1);
        end
      end
    end
  end

  assign tool_addr_s = A_W'(bus.tool_y) * A_W'(WIDTH) + A_W'(bus.tool_x);

  // Tool write qualification: in range, active layer visible, no sweep running.
  always_comb begin
    tool_we_s = 1'b0;
    if (bus.tool_valid && layer_visible[active_layer_r] && !busy_s &&
        (bus.tool_x < X_LIMIT) && (bus.tool_y < Y_LIMIT)) begin
      tool_we_s = 1'b1;
    end else begin
      tool_we_s = 1'b0;
    end
  end

`ifdef LAYER_STACK_CLEAR_EN
  localparam logic [A_W-1:0] LAST_ADDR = A_W'(DEPTH - 1);

  clear_state_e   state_r;
  clear_state_e   state_s;
  logic [L_W-1:0] target_r;
  logic [L_W-1:0] target_s;
  logic [A_W-1:0] clr_addr_r;
  logic [A_W-1:0] clr_addr_s;
  logic           busy_r;

  // Clear sweep state, target layer and sweep address; busy mirrors the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= CS_IDLE;
      target_r   <= {L_W{1'b0}};
      clr_addr_r <= {A_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      target_r   <= target_s;
      clr_addr_r <= clr_addr_s;
      busy_r     <= (state_s == CS_CLEAR);
    end
  end

  // Sweep control: latch the target on request, then erase one pixel per cycle.
  always_comb begin
    state_s    = state_r;
    target_s   = target_r;
    clr_addr_s = clr_addr_r;
    clr_we_s   = 1'b0;
    case (state_r)
      CS_IDLE: begin
        if (clear_req) begin
          state_s    = CS_CLEAR;
          target_s   = active_layer_r;
          clr_addr_s = {A_W{1'b0}};
        end else begin
          state_s    = CS_IDLE;
        end
      end
      CS_CLEAR: begin
        // A reset landing mid-sweep must not erase one more pixel.
        clr_we_s = !reset;
        if (clr_addr_r == LAST_ADDR) begin
          state_s    = CS_IDLE;
          clr_addr_s = {A_W{1'b0}};
        end else begin
          clr_addr_s = clr_addr_r + A_W'(1);
        end
      end
      default: begin
        state_s    = CS_IDLE;
        clr_addr_s = {A_W{1'b0}};
      end
    endcase
  end

  assign clr_target_s = target_r;
  assign clr_waddr_s  = clr_addr_r;
  assign busy_s       = busy_r;
`else
  logic clear_req_unused_s;

  assign clear_req_unused_s = clear_req;
  assign clr_we_s           = 1'b0;
  assign clr_target_s       = {L_W{1'b0}};
  assign clr_waddr_s        = {A_W{1'b0}};
  assign busy_s             = 1'b0;
`endif

  // Shared write port: the sweep and tool writes never overlap.
  always_comb begin
    ram_waddr_s = tool_addr_s;
    ram_wdata_s = bus.tool_color;
    if (clr_we_s) begin
      ram_waddr_s = clr_waddr_s;
      ram_wdata_s = COLOR_NONE;
    end else begin
      ram_waddr_s = tool_addr_s;
      ram_wdata_s = bus.tool_color;
    end
  end

  assign req_ok_s   = (bus.request_x < X_LIMIT) && (bus.request_y < Y_LIMIT);
  assign req_addr_s = A_W'(bus.request_y) * A_W'(WIDTH) + A_W'(bus.request_x);

  genvar g;
  generate
    for (g = 0; g < NUM_LAYERS; g++) begin : g_layer
      assign ram_we_s[g] = (tool_we_s && (active_layer_r == L_W'(g))) ||
                           (clr_we_s && (clr_target_s == L_W'(g)));
      layer_ram #(.DEPTH(DEPTH), .AW(A_W)) u_ram (
        .clk   (clk),
        .we    (ram_we_s[g]),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (req_addr_r),
        .rdata (rd_data_s[g])
      );
    end
  endgenerate

  // Topmost visible painted layer wins; later (higher) layers override.
  always_comb begin
    mix_color_s = COLOR_NONE;
    mix_hit_s   = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (rd_ok_r && layer_visible[i] && color_present(rd_data_s[i])) begin
        mix_color_s = rd_data_s[i];
        mix_hit_s   = 1'b1;
      end else begin
        mix_color_s = mix_color_s;
        mix_hit_s   = mix_hit_s;
      end
    end
  end

  // Read pipeline: register request, track validity past the RAM read, register result.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr_r    <= {A_W{1'b0}};
      req_ok_r      <= 1'b0;
      rd_ok_r       <= 1'b0;
      pixel_color_r <= COLOR_NONE;
      pixel_hit_r   <= 1'b0;
    end else begin
      req_addr_r    <= req_ok_s ? req_addr_s : {A_W{1'b0}};
      req_ok_r      <= req_ok_s;
      rd_ok_r       <= req_ok_r;
      pixel_color_r <= mix_color_s;
      pixel_hit_r   <= mix_hit_s;
    end
  end

  assign active_layer    = active_layer_r;
  assign clear_busy      = busy_s;
  assign bus.pixel_color = pixel_color_r;
  assign bus.pixel_hit   = pixel_hit_r;

endmodule

// File: tb/tb_layer_stack.sv
// Directed bench for layer_stack at 8x8, 4 layers. The clear-sweep checks
// run when LAYER_STACK_CLEAR_EN is defined, the clear-disabled checks otherwise.
module tb_layer_stack;
  import layer_stack_pkg::*;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       layer_toggle;
  logic [3:0] layer_visible;
  logic       clear_req;
  logic [1:0] active_layer;
  logic       clear_busy;

  int checks = 0;
  int errors = 0;

  layer_stack_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  layer_stack #(.WIDTH(W), .HEIGHT(H), .NUM_LAYERS(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .layer_toggle  (layer_toggle),
    .layer_visible (layer_visible),
    .clear_req     (clear_req),
    .active_layer  (active_layer),
    .clear_busy    (clear_busy),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_toggle();
    layer_toggle = 1'b1;
    tick();
    layer_toggle = 1'b0;
    tick();
  endtask

  task automatic write_px(input int x, input int y, input int c);
    bus.tool_valid = 1'b1;
    bus.tool_x     = 4'(x);
    bus.tool_y     = 4'(y);
    bus.tool_color = 4'(c);
    tick();
    bus.tool_valid = 1'b0;
  endtask

  task automatic read_px(input int x, input int y, output int c, output int hit);
    bus.request_x = 4'(x);
    bus.request_y = 4'(y);
    tick();
    tick();
    tick();
    c   = int'(bus.pixel_color);
    hit = int'(bus.pixel_hit);
  endtask

  task automatic expect_px(input string tag, input int x, input int y, input int c, input int hit);
    int gc;
    int gh;
    read_px(x, y, gc, gh);
    check_value({tag, "_color"}, gc, c);
    check_value({tag, "_hit"}, gh, hit);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    reset          = 1'b1;
    layer_toggle   = 1'b0;
    layer_visible  = 4'b1111;
    clear_req      = 1'b0;
    bus.tool_valid = 1'b0;
    bus.tool_x     = 4'd0;
    bus.tool_y     = 4'd0;
    bus.tool_color = 4'd0;
    bus.request_x  = 4'd5;
    bus.request_y  = 4'd5;
    do_reset();

    // Give every layer a known empty image.
    for (int l = 0; l < N; l++) begin
      for (int a = 0; a < W * H; a++) write_px(a % W, a / W, 0);
      pulse_toggle();
    end
    bus.request_x = 4'd5;
    bus.request_y = 4'd5;
    do_reset();

    // Reset state
    check_value("rst_active", int'(active_layer), 0);
    check_value("rst_color", int'(bus.pixel_color), 0);
    check_value("rst_hit", int'(bus.pixel_hit), 0);
    check_value("rst_busy", int'(clear_busy), 0);

    // Layer select
    pulse_toggle();
    pulse_toggle();
    check_value("sel_two_pulses", int'(active_layer), 2);
    layer_toggle = 1'b1;
    repeat (5) tick();
    check_value("sel_hold_high", int'(active_layer), 3);
    layer_toggle = 1'b0;
    tick();
    pulse_toggle();
    check_value("sel_wrap", int'(active_layer), 0);

    // Priority
    write_px(1, 2, 3);
    pulse_toggle();
    pulse_toggle();
    check_value("sel_layer2", int'(active_layer), 2);
    write_px(1, 2, 5);
    expect_px("prio_top", 1, 2, 5, 1);
    layer_visible = 4'b1011;
    expect_px("prio_l2_hidden", 1, 2, 3, 1);
    layer_visible = 4'b1010;
    expect_px("prio_none_vis", 1, 2, 0, 0);
    layer_visible = 4'b1111;

    // Dropped writes
    layer_visible = 4'b1011;
    write_px(3, 3, 7);
    layer_visible = 4'b1111;
    expect_px("drop_invisible", 3, 3, 0, 0);
    write_px(8, 3, 9);
    expect_px("drop_x8_alias03", 0, 3, 0, 0);
    expect_px("drop_x8_alias04", 0, 4, 0, 0);
    write_px(2, 8, 9);
    expect_px("drop_y8_alias20", 2, 0, 0, 0);

    // Read edges
    expect_px("rd_empty", 5, 5, 0, 0);
    write_px(0, 0, 1);
    write_px(7, 7, 14);
    bus.request_x = 4'd0; bus.request_y = 4'd0; tick();
    bus.request_x = 4'd1; bus.request_y = 4'd2; tick();
    bus.request_x = 4'd7; bus.request_y = 4'd7; tick();
    check_value("b2b_0_color", int'(bus.pixel_color), 1);
    tick();
    check_value("b2b_1_color", int'(bus.pixel_color), 5);
    tick();
    check_value("b2b_2_color", int'(bus.pixel_color), 14);
    check_value("b2b_2_hit", int'(bus.pixel_hit), 1);
    expect_px("rd_out_of_range", 8, 0, 0, 0);

    // Read-first: write lands on the same edge as the RAM read of that address.
    bus.request_x = 4'd2; bus.request_y = 4'd2;
    tick();
    bus.tool_valid = 1'b1; bus.tool_x = 4'd2; bus.tool_y = 4'd2; bus.tool_color = 4'd6;
    tick();
    bus.tool_valid = 1'b0;
    tick();
    check_value("rdfirst_old", int'(bus.pixel_color), 0);
    expect_px("rdfirst_new", 2, 2, 6, 1);

`ifdef LAYER_STACK_CLEAR_EN
    // Clear of layer 2, with a tool write attempted mid-sweep
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!clear_busy) break;
      cnt++;
      if (i == 5) begin
        bus.tool_valid = 1'b1; bus.tool_x = 4'd4; bus.tool_y = 4'd4; bus.tool_color = 4'd8;
      end else begin
        bus.tool_valid = 1'b0;
      end
      tick();
    end
    bus.tool_valid = 1'b0;
    check_value("clr_busy_cycles", cnt, 64);
    expect_px("clr_write_dropped", 4, 4, 0, 0);
    expect_px("clr_layer0_kept", 1, 2, 3, 1);
    expect_px("clr_l2_00", 0, 0, 0, 0);

    // Reset in the middle of a sweep
    for (int a = 0; a < W * H; a++) write_px(a % W, a / W, (a % 15) + 1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_value("clr_rst_busy", int'(clear_busy), 0);
    layer_visible = 4'b0100;
    for (int a = 0; a < W * H; a++) begin
      expect_px($sformatf("clr_rst_a%0d", a), a % W, a / W, (a < 10) ? 0 : (a % 15) + 1, (a < 10) ? 0 : 1);
    end
`else
    // Clear disabled
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check_value("noclr_busy_now", int'(clear_busy), 0);
    repeat (10) tick();
    check_value("noclr_busy_later", int'(clear_busy), 0);
    layer_visible = 4'b0100;
    expect_px("noclr_l2_kept", 1, 2, 5, 1);
    expect_px("noclr_l2_77", 7, 7, 14, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
